// File: rtl/data_memory_mc_if.sv
// Request/response bundle between the MEM stage and the multi-cycle data memory.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready for requests, rsp_valid/rsp_ready for responses.
// Ports (master = MEM stage, slave = memory):
//   req_valid/req_write/req_funct3/req_addr/req_wdata  master -> slave
//   req_ready                                           slave  -> master
//   rsp_valid/rsp_rdata/rsp_error                       slave  -> master
//   rsp_ready                                           master -> slave
interface data_memory_mc_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_mc.sv
// RV32I load/store data memory with byte/half/word access, alignment checks and extension.
// Latency: response visible LATENCY cycles after the accept cycle; one request in flight.
// Backpressure: req_ready only in IDLE; RESP holds rdata/error stable until rsp_ready.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset (memory array itself is not cleared)
//   bus    data_memory_mc_if.slave request/response bundle
module data_memory_mc #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clock,
  input  logic            reset,
  data_memory_mc_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept, exec;
  logic        cur_wr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] widx;
  logic [31:0] rd_word, wr_word, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        acc_err;

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // With LATENCY==1 the access executes on the accept edge itself, so the
  // operands come straight from the bus; otherwise from the captured copy.
  assign exec = (accept && (LATENCY == 1)) || ((state_q == S_BUSY) && (cnt_q == 4'd1));

  assign cur_wr    = (state_q == S_IDLE) ? bus.req_write  : wr_q;
  assign cur_f3    = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;
  assign cur_addr  = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;

  // Out-of-range indices may alias here; acc_err masks both the write and the result.
  assign widx    = cur_addr[AW+1:2];
  assign rd_word = mem_q[widx];

  always_comb begin
    acc_err = 1'b0;
    case (cur_f3)
      3'b011, 3'b110, 3'b111: acc_err = 1'b1;
      3'b100, 3'b101:         acc_err = cur_wr;   // no unsigned store forms
      default:                acc_err = 1'b0;
    endcase
    if ((cur_f3[1:0] == 2'b01) && cur_addr[0])          acc_err = 1'b1;
    if ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)) acc_err = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))     acc_err = 1'b1;
  end

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = rd_word;
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = 32'd0;
    endcase
  end

  // Read-modify-write merge so unwritten lanes keep their old contents.
  always_comb begin
    wr_word = rd_word;
    case (cur_f3[1:0])
      2'b00: begin
        case (cur_addr[1:0])
          2'd0:    wr_word[7:0]   = cur_wdata[7:0];
          2'd1:    wr_word[15:8]  = cur_wdata[7:0];
          2'd2:    wr_word[23:16] = cur_wdata[7:0];
          default: wr_word[31:24] = cur_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (cur_addr[1]) wr_word[31:16] = cur_wdata[15:0];
        else             wr_word[15:0]  = cur_wdata[15:0];
      end
      default: wr_word = cur_wdata;
    endcase
  end

  assign rdata_d = (acc_err || cur_wr) ? 32'd0 : ld_val;
  assign err_d   = acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (exec) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Array has no reset; reset on the execute edge blocks the commit.
  always_ff @(posedge clock) begin
    if (!reset && exec && cur_wr && !acc_err) begin
      mem_q[widx] <= wr_word;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;
  localparam int DEPTH = 256;
  localparam int L2 = 0;  // index of the LATENCY=2 instance
  localparam int L1 = 1;  // index of the LATENCY=1 instance

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_memory_mc_if bus2 ();
  data_memory_mc_if bus1 ();

  data_memory_mc #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );
  data_memory_mc #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] ref_mem [2][DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int sel);
    return (sel == L1) ? bus1.rsp_valid : bus2.rsp_valid;
  endfunction
  function automatic logic rdy(input int sel);
    return (sel == L1) ? bus1.req_ready : bus2.req_ready;
  endfunction
  function automatic logic [31:0] rdat(input int sel);
    return (sel == L1) ? bus1.rsp_rdata : bus2.rsp_rdata;
  endfunction
  function automatic logic rerr(input int sel);
    return (sel == L1) ? bus1.rsp_error : bus2.rsp_error;
  endfunction

  task automatic drive(input int sel, input logic v, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == L1) begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_funct3 = f3;
      bus1.req_addr = a;  bus1.req_wdata = wd;
    end else begin
      bus2.req_valid = v; bus2.req_write = w; bus2.req_funct3 = f3;
      bus2.req_addr = a;  bus2.req_wdata = wd;
    end
  endtask

  // Reference: RV32I access rules applied to a plain word array.
  task automatic model(input int sel, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size, off, idx;
    logic [31:0] word;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    er = 1'b0;
    if (size == 0 || f3 == 3'b110) er = 1'b1;
    if (w && f3 >= 3'd4) er = 1'b1;
    if (size > 1 && (a % size) != 0) er = 1'b1;
    if ((a / 4) >= DEPTH) er = 1'b1;
    rd = 32'd0;
    if (!er) begin
      idx = int'(a / 4);
      off = int'(a % 4);
      word = ref_mem[sel][idx];
      if (w) begin
        for (int k = 0; k < size; k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
        ref_mem[sel][idx] = word;
      end else begin
        rd = word >> (8 * off);
        if (size == 1) rd = rd & 32'hFF;
        else if (size == 2) rd = rd & 32'hFFFF;
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
      end
    end
  endtask

  // Starts and ends on a falling edge; leaves the DUT back in IDLE.
  task automatic txn(input int sel, input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output int acc);
    logic got;
    drive(sel, 1'b1, w, f3, a, wd);
    chk($sformatf("req_ready_idle[%0d]", sel), 32'(rdy(sel)), 32'd1);
    @(posedge clock); #1;
    acc = cyc;
    drive(sel, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    lat = 0;
    got = 1'b0;
    while (got !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
      got = vld(sel);
    end
    chk($sformatf("rsp_timeout[%0d]", sel), 32'(got), 32'd1);
    rd = rdat(sel);
    er = rerr(sel);
    @(negedge clock);
    chk($sformatf("rsp_one_cycle[%0d]", sel), 32'(vld(sel)), 32'd0);
    chk($sformatf("req_ready_back[%0d]", sel), 32'(rdy(sel)), 32'd1);
  endtask

  task automatic run(input string tag, input int sel, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int acc);
    logic [31:0] mrd;
    logic mer;
    int lat;
    model(sel, w, f3, a, wd, mrd, mer);
    txn(sel, w, f3, a, wd, rd, er, lat, acc);
    chk({tag, "_rdata"}, rd, mrd);
    chk({tag, "_error"}, 32'(er), 32'(mer));
    chk({tag, "_latency"}, 32'(lat), (sel == L1) ? 32'd1 : 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd, a, wd;
    logic er, mer, got, w;
    logic [2:0] f3;
    int acc, acc2;

    reset = 1'b1;
    drive(L2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(L1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    bus2.rsp_ready = 1'b1;
    bus1.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_req_ready[%0d]", s), 32'(rdy(s)), 32'd1);
      chk($sformatf("reset_rsp_valid[%0d]", s), 32'(vld(s)), 32'd0);
      chk($sformatf("reset_rdata[%0d]", s), rdat(s), 32'd0);
      chk($sformatf("reset_error[%0d]", s), 32'(rerr(s)), 32'd0);
    end

    // Directed accesses around word 0x10.
    run("sw_10", L2, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, acc);
    run("lw_10", L2, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, acc);
    chk("lw_10_const", rd, 32'hDEAD_BEEF);
    run("lb_13", L2, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, acc);
    chk("lb_13_const", rd, 32'hFFFF_FFDE);
    run("lbu_13", L2, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, acc);
    chk("lbu_13_const", rd, 32'h0000_00DE);
    run("lh_10", L2, 1'b0, 3'b001, 32'h10, 32'h0, rd, er, acc);
    chk("lh_10_const", rd, 32'hFFFF_BEEF);
    run("lhu_12", L2, 1'b0, 3'b101, 32'h12, 32'h0, rd, er, acc);
    chk("lhu_12_const", rd, 32'h0000_DEAD);
    run("sb_11", L2, 1'b1, 3'b000, 32'h11, 32'hAAAA_AA55, rd, er, acc);
    run("lw_10_after_sb", L2, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, acc);
    chk("lw_10_after_sb_const", rd, 32'hDEAD_55EF);

    // Error cases.
    run("lw_misaligned", L2, 1'b0, 3'b010, 32'h12, 32'h0, rd, er, acc);
    chk("lw_misaligned_err_const", 32'(er), 32'd1);
    run("sh_misaligned", L2, 1'b1, 3'b001, 32'h11, 32'h1234_5678, rd, er, acc);
    chk("sh_misaligned_err_const", 32'(er), 32'd1);
    run("lw_after_bad_sh", L2, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, acc);
    chk("lw_after_bad_sh_const", rd, 32'hDEAD_55EF);
    run("lw_oob", L2, 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, rd, er, acc);
    chk("lw_oob_err_const", 32'(er), 32'd1);
    run("f3_011", L2, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, acc);
    chk("f3_011_err_const", 32'(er), 32'd1);
    run("sbu_store", L2, 1'b1, 3'b100, 32'h10, 32'h0, rd, er, acc);

    // Backpressure: response must hold while rsp_ready is low.
    model(L2, 1'b0, 3'b010, 32'h10, 32'h0, mrd, mer);
    bus2.rsp_ready = 1'b0;
    drive(L2, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clock); #1;
    drive(L2, 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    got = 1'b0;
    for (int i = 0; i < 20 && got !== 1'b1; i++) begin
      @(negedge clock);
      got = bus2.rsp_valid;
    end
    chk("bp_timeout", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), 32'(bus2.rsp_valid), 32'd1);
      chk($sformatf("bp_rdata_%0d", k), bus2.rsp_rdata, mrd);
      chk($sformatf("bp_error_%0d", k), 32'(bus2.rsp_error), 32'(mer));
      chk($sformatf("bp_req_ready_%0d", k), 32'(bus2.req_ready), 32'd0);
      @(negedge clock);
    end
    bus2.rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_released_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("bp_released_ready", 32'(bus2.req_ready), 32'd1);

    // Reset on the execute edge of a store: no commit, no response.
    run("sw_20_zero", L2, 1'b1, 3'b010, 32'h20, 32'h0, rd, er, acc);
    run("lw_10_prime", L2, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, acc);
    drive(L2, 1'b1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
    @(posedge clock); #1;
    drive(L2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("abort_rdata", bus2.rsp_rdata, 32'd0);
    chk("abort_error", 32'(bus2.rsp_error), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("abort_no_rsp_%0d", k), 32'(bus2.rsp_valid), 32'd0);
    end
    run("lw_20_after_abort", L2, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, acc);
    chk("lw_20_after_abort_const", rd, 32'd0);

    // LATENCY=1 instance: back-to-back store then load.
    run("l1_sw_40", L1, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, rd, er, acc);
    run("l1_lw_40", L1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, acc2);
    chk("l1_lw_40_const", rd, 32'hCAFE_F00D);
    chk("l1_spacing", 32'(acc2 - acc), 32'd2);

    // Randomized traffic over an initialised window plus out-of-range hits.
    for (int s = 0; s < 2; s++) begin
      for (int wi = 0; wi < 16; wi++)
        run("rnd_init", s, 1'b1, 3'b010, 32'(4 * wi), $urandom, rd, er, acc);
      for (int n = 0; n < 60; n++) begin
        w  = 1'($urandom);
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
        else a = 32'($urandom_range(0, 63));
        run($sformatf("rnd_%0d_%0d", s, n), s, w, f3, a, wd, rd, er, acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
